// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: alu_op codes, R-type funct codes,
// FSM state and internal ALU control.
// Latency: n/a (types and constants only).  Backpressure: n/a.
package ex_pkg;

    // alu_op field as presented by decode
    typedef enum logic [1:0] {
        AOP_MEM   = 2'b00,  // LW/SW/ADDI: add immediate
        AOP_BEQ   = 2'b01,  // compare by subtraction
        AOP_RTYPE = 2'b10,  // operation chosen by funct
        AOP_RSVD  = 2'b11
    } alu_op_e;

    // R-type funct codes, taken from sign_ext[5:0]
    localparam logic [5:0] FN_ADD = 6'b000000;
    localparam logic [5:0] FN_SUB = 6'b000001;
    localparam logic [5:0] FN_MUL = 6'b000010;

    // Stage-level FSM
    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } ex_state_e;

    // Resolved operation after decode
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10,
        ALU_BAD = 2'b11
    } alu_ctl_e;

    // Width of the multiplier cycle counter; holds MUL_LATENCY-1 for 1..8
    localparam int MUL_CNT_W = 4;

    // Map alu_op/funct onto the ALU control; anything unrecognised is BAD
    function automatic alu_ctl_e decode_op(input logic [1:0] alu_op,
                                           input logic [5:0] funct);
        alu_ctl_e ctl;
        ctl = ALU_BAD;
        case (alu_op_e'(alu_op))
            AOP_MEM:   ctl = ALU_ADD;
            AOP_BEQ:   ctl = ALU_SUB;
            AOP_RTYPE: begin
                case (funct)
                    FN_ADD:  ctl = ALU_ADD;
                    FN_SUB:  ctl = ALU_SUB;
                    FN_MUL:  ctl = ALU_MUL;
                    default: ctl = ALU_BAD;
                endcase
            end
            default:   ctl = ALU_BAD;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Multi-cycle unsigned multiplier (low DATA_W bits) with start/done/take handshake.
// Latency: done rises MUL_LATENCY-1 cycles after start (for MUL_LATENCY >= 2).
// Backpressure: once done, result is held (counter parked at 0) until take.
//
// Ports:
//   clk, reset   : clock, synchronous active-low reset
//   start        : capture a/b and begin counting
//   a, b         : operands, sampled only on start
//   take         : consumer accepts product this cycle (only meaningful with done)
//   done         : product valid and waiting
//   product      : low DATA_W bits of a*b
module ex_mul_iter
    import ex_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MUL_LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              take,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam logic [MUL_CNT_W-1:0] CNT_INIT = MUL_CNT_W'(MUL_LATENCY - 1);

    logic                 busy;
    logic [MUL_CNT_W-1:0] count;
    logic [DATA_W-1:0]    a_q;
    logic [DATA_W-1:0]    b_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy  <= 1'b0;
            count <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= CNT_INIT;
            a_q   <= a;
            b_q   <= b;
        end else if (busy) begin
            // count steps down every cycle and parks at 0 while the result waits
            if (count != '0) begin
                count <= count - 1'b1;
            end
            if (take) begin
                busy <= 1'b0;
            end
        end
    end

    // The result is presented at the edge where count reaches 0, so the
    // completing edge is the one seen with count == 1 (or later, parked at 0).
    // Together with the accept cycle this gives MUL_LATENCY cycles of occupancy.
    assign done    = busy && (count <= MUL_CNT_W'(1));

    // Operands are stable in a_q/b_q for the whole busy window, so the
    // product path has MUL_LATENCY-1 cycles to settle.
    assign product = a_q * b_q;

endmodule

// File: rtl/ex_stage_pipelined.sv
// Execute stage: ALU, zero flag, branch resolution and multi-cycle MUL, all outputs registered.
// Latency: 1 cycle for ADD/SUB/bad ops; MUL_LATENCY cycles for MUL (accept cycle included).
// Backpressure: ready_out drops while a MUL is in flight or the output slot is full and not drained.
//
// Ports:
//   clk, reset                     : clock, synchronous active-low reset
//   valid_in / ready_out           : decode -> execute handshake
//   rs, rt, sign_ext, pc           : operands (sign_ext[5:0] is funct for R-type)
//   alu_src, alu_op, branch        : decoded control
//   valid_out / ready_in           : execute -> memory handshake
//   result_out, zero_out           : ALU result and data1 == data2
//   branch_taken, branch_target    : branch resolution, target = pc + (sign_ext << BR_SHIFT)
//   pc_out                         : branch_target when taken, else pc
//   bad_op                         : reserved alu_op or unknown funct (result forced to 0)
// Optional: EX_FORWARD_EN adds fwd_rs_en, fwd_rt_en, fwd_data operand overrides.
module ex_stage_pipelined
    import ex_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MUL_LATENCY = 3,
    parameter int BR_SHIFT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    input  logic [DATA_W-1:0] sign_ext,
    input  logic [DATA_W-1:0] pc,
    input  logic              alu_src,
    input  logic [1:0]        alu_op,
    input  logic              branch,
`ifdef EX_FORWARD_EN
    input  logic              fwd_rs_en,
    input  logic              fwd_rt_en,
    input  logic [DATA_W-1:0] fwd_data,
`endif
    output logic              valid_out,
    input  logic              ready_in,
    output logic [DATA_W-1:0] result_out,
    output logic              zero_out,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    output logic [DATA_W-1:0] pc_out,
    output logic              bad_op
);

    // Everything the stage presents downstream, registered as one unit
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              taken;
        logic [DATA_W-1:0] target;
        logic [DATA_W-1:0] pc_sel;
        logic              bad;
    } ex_res_t;

    // ---------------------------------------------------------------
    // Operand selection
    // ---------------------------------------------------------------
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_rt;
    logic [DATA_W-1:0] op_b;

`ifdef EX_FORWARD_EN
    assign op_a  = fwd_rs_en ? fwd_data : rs;
    assign op_rt = fwd_rt_en ? fwd_data : rt;
`else
    assign op_a  = rs;
    assign op_rt = rt;
`endif

    // Memory-class ops always use the immediate regardless of alu_src;
    // forwarding of rt happens before this mux.
    assign op_b = (alu_op == AOP_MEM) ? sign_ext : (alu_src ? sign_ext : op_rt);

    alu_ctl_e alu_ctl;
    assign alu_ctl = decode_op(alu_op, sign_ext[5:0]);

    // A single-cycle MUL uses a combinational product; otherwise the
    // iterative unit owns the multiply and this path is tied off.
    logic [DATA_W-1:0] mul_comb;
    generate
        if (MUL_LATENCY == 1) begin : g_mul_comb
            assign mul_comb = op_a * op_b;
        end else begin : g_mul_none
            assign mul_comb = '0;
        end
    endgenerate

    // ---------------------------------------------------------------
    // ALU and branch resolution for the operation at the input
    // ---------------------------------------------------------------
    ex_res_t res_d;

    always_comb begin
        res_d        = '0;
        res_d.zero   = (op_a == op_b);
        res_d.target = pc + (sign_ext << BR_SHIFT);
        res_d.taken  = branch && res_d.zero;
        res_d.pc_sel = res_d.taken ? res_d.target : pc;
        case (alu_ctl)
            ALU_ADD: res_d.result = op_a + op_b;
            ALU_SUB: res_d.result = op_a - op_b;
            ALU_MUL: res_d.result = mul_comb;
            default: begin
                res_d.result = '0;
                res_d.bad    = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------
    ex_state_e state_q;
    ex_state_e state_d;
    logic      valid_q;
    logic      slot_free;
    logic      accept;
    logic      mul_multi;
    logic      mul_start;
    logic      load_now;
    logic      mul_done;
    logic      mul_take;
    logic [DATA_W-1:0] mul_product;

    // Output register can take a new result if empty or being drained now
    assign slot_free = !valid_q || ready_in;
    assign ready_out = (state_q == IDLE) && slot_free;
    assign accept    = valid_in && ready_out;

    assign mul_multi = (alu_ctl == ALU_MUL) && (MUL_LATENCY > 1);
    assign mul_start = accept && mul_multi;
    assign load_now  = accept && !mul_multi;
    assign mul_take  = (state_q == MUL_BUSY) && mul_done && slot_free;

    ex_mul_iter #(
        .DATA_W      (DATA_W),
        .MUL_LATENCY (MUL_LATENCY)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .take    (mul_take),
        .done    (mul_done),
        .product (mul_product)
    );

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (mul_start) state_d = MUL_BUSY;
            MUL_BUSY: if (mul_take)  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Pending fields for an in-flight MUL and the output register
    // ---------------------------------------------------------------
    // Flags, target and pc_out of a MUL are resolved from the operands at
    // accept and parked here; only the product arrives later.
    ex_res_t pend_q;
    ex_res_t out_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_q <= '0;
        end else if (mul_start) begin
            pend_q <= res_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_now) begin
            out_q   <= res_d;
            valid_q <= 1'b1;
        end else if (mul_take) begin
            out_q        <= pend_q;
            out_q.result <= mul_product;
            valid_q      <= 1'b1;
        end else if (ready_in) begin
            // drained with nothing new behind it; data held, only valid drops
            valid_q <= 1'b0;
        end
    end

    assign valid_out     = valid_q;
    assign result_out    = out_q.result;
    assign zero_out      = out_q.zero;
    assign branch_taken  = out_q.taken;
    assign branch_target = out_q.target;
    assign pc_out        = out_q.pc_sel;
    assign bad_op        = out_q.bad;

endmodule

// File: tb/tb_ex_stage_pipelined.sv
// Self-checking bench for ex_stage_pipelined: directed scenarios plus a randomized
// stream checked against an in-bench reference model and an ordered scoreboard.
// Runs the default build; EX_FORWARD_EN ports are tied off when that macro is set.
module tb_ex_stage_pipelined;

    localparam int DW  = 32;
    localparam int LAT = 3;

    logic          clk;
    logic          reset;
    logic          valid_in;
    logic          ready_out;
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
    logic [DW-1:0] sign_ext;
    logic [DW-1:0] pc;
    logic          alu_src;
    logic [1:0]    alu_op;
    logic          branch;
    logic          valid_out;
    logic          ready_in;
    logic [DW-1:0] result_out;
    logic          zero_out;
    logic          branch_taken;
    logic [DW-1:0] branch_target;
    logic [DW-1:0] pc_out;
    logic          bad_op;
`ifdef EX_FORWARD_EN
    logic          fwd_rs_en;
    logic          fwd_rt_en;
    logic [DW-1:0] fwd_data;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [DW-1:0] result;
        logic          zero;
        logic          taken;
        logic [DW-1:0] target;
        logic [DW-1:0] pcsel;
        logic          bad;
    } exp_t;

    exp_t exp_q[$];

    ex_stage_pipelined #(
        .DATA_W      (DW),
        .MUL_LATENCY (LAT),
        .BR_SHIFT    (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .rs            (rs),
        .rt            (rt),
        .sign_ext      (sign_ext),
        .pc            (pc),
        .alu_src       (alu_src),
        .alu_op        (alu_op),
        .branch        (branch),
`ifdef EX_FORWARD_EN
        .fwd_rs_en     (fwd_rs_en),
        .fwd_rt_en     (fwd_rt_en),
        .fwd_data      (fwd_data),
`endif
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .result_out    (result_out),
        .zero_out      (zero_out),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_out        (pc_out),
        .bad_op        (bad_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Reference: the instruction-set meaning of one operation
    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] rtv,
                                   input logic [DW-1:0] se, input logic [DW-1:0] p,
                                   input logic src, input logic [1:0] op, input logic br);
        exp_t e;
        logic [DW-1:0] b;
        b = (op == 2'b00 || src) ? se : rtv;
        e = '0;
        case (op)
            2'b00: e.result = a + b;
            2'b01: e.result = a - b;
            2'b10: begin
                if (se[5:0] == 6'd0)      e.result = a + b;
                else if (se[5:0] == 6'd1) e.result = a - b;
                else if (se[5:0] == 6'd2) e.result = a * b;
                else                      e.bad = 1'b1;
            end
            default: e.bad = 1'b1;
        endcase
        e.zero   = (a == b);
        e.target = p + (se << 2);
        e.taken  = br && e.zero;
        e.pcsel  = e.taken ? e.target : p;
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.result = result_out;
        o.zero   = zero_out;
        o.taken  = branch_taken;
        o.target = branch_target;
        o.pcsel  = pc_out;
        o.bad    = bad_op;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] se, input logic [DW-1:0] p,
                          input logic src, input logic [1:0] op, input logic br);
        rs = a; rt = b; sign_ext = se; pc = p; alu_src = src; alu_op = op; branch = br;
    endtask

    task automatic test_reset();
        reset = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        set_op(0, 0, 0, 0, 1'b0, 2'b00, 1'b0);
        tick(); tick();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid_out); end
        checks++; if (result_out !== '0) begin failures++; $display("FAIL reset_result got=%h want=0", result_out); end
        checks++; if ({zero_out, branch_taken, bad_op} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b want=000", {zero_out, branch_taken, bad_op}); end
        checks++; if (branch_target !== '0 || pc_out !== '0) begin failures++; $display("FAIL reset_pc got=%h/%h want=0/0", branch_target, pc_out); end
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", ready_out); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        set_op(5, 0, 7, 0, 1'b0, 2'b00, 1'b0);
        valid_in = 1'b1; ready_in = 1'b1;
        #1;
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL addi_ready got=%b want=1", ready_out); end
        tick();
        valid_in = 1'b0;
        checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL addi_valid got=%b want=1", valid_out); end
        checks++; if (result_out !== 32'd12) begin failures++; $display("FAIL addi_result got=%0d want=12", result_out); end
        checks++; if (bad_op !== 1'b0) begin failures++; $display("FAIL addi_bad got=%b want=0", bad_op); end
        tick();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL addi_drain got=%b want=0", valid_out); end
    endtask

    task automatic test_beq();
        set_op(9, 9, 4, 32'h100, 1'b0, 2'b01, 1'b1);
        valid_in = 1'b1; ready_in = 1'b1;
        tick();
        set_op(9, 8, 4, 32'h100, 1'b0, 2'b01, 1'b1);
        checks++; if (zero_out !== 1'b1 || branch_taken !== 1'b1) begin failures++; $display("FAIL beq_taken_flags got=%b%b want=11", zero_out, branch_taken); end
        checks++; if (branch_target !== 32'h110) begin failures++; $display("FAIL beq_target got=%h want=110", branch_target); end
        checks++; if (pc_out !== 32'h110) begin failures++; $display("FAIL beq_pc_taken got=%h want=110", pc_out); end
        tick();
        valid_in = 1'b0;
        checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL beq_b2b_valid got=%b want=1", valid_out); end
        checks++; if (zero_out !== 1'b0 || branch_taken !== 1'b0) begin failures++; $display("FAIL beq_nt_flags got=%b%b want=00", zero_out, branch_taken); end
        checks++; if (pc_out !== 32'h100 || branch_target !== 32'h110) begin failures++; $display("FAIL beq_pc_not_taken got=%h/%h want=100/110", pc_out, branch_target); end
        tick();
    endtask

    task automatic test_mul();
        set_op(6, 7, 32'h2, 0, 1'b0, 2'b10, 1'b0);
        valid_in = 1'b1; ready_in = 1'b1;
        tick();
        set_op(3, 4, 32'h0, 0, 1'b0, 2'b10, 1'b0);
        for (int c = 0; c < LAT - 1; c++) begin
            checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL mul_busy_ready c=%0d got=%b want=0", c, ready_out); end
            checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL mul_busy_valid c=%0d got=%b want=0", c, valid_out); end
            tick();
        end
        checks++; if (valid_out !== 1'b1 || result_out !== 32'd42) begin failures++; $display("FAIL mul_result got=%b/%0d want=1/42", valid_out, result_out); end
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL mul_ready_after got=%b want=1", ready_out); end
        tick();
        valid_in = 1'b0;
        checks++; if (valid_out !== 1'b1 || result_out !== 32'd7) begin failures++; $display("FAIL mul_next_add got=%b/%0d want=1/7", valid_out, result_out); end
        tick();
    endtask

    task automatic test_backpressure();
        exp_t snap;
        ready_in = 1'b0;
        set_op(100, 0, 23, 0, 1'b0, 2'b00, 1'b0);
        valid_in = 1'b1;
        tick();
        set_op(1000, 0, 1, 0, 1'b0, 2'b00, 1'b0);
        checks++; if (valid_out !== 1'b1 || result_out !== 32'd123) begin failures++; $display("FAIL bp_first got=%b/%0d want=1/123", valid_out, result_out); end
        snap = observe();
        for (int c = 0; c < 5; c++) begin
            checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL bp_ready c=%0d got=%b want=0", c, ready_out); end
            tick();
            checks++; if (valid_out !== 1'b1 || observe() !== snap) begin failures++; $display("FAIL bp_stable c=%0d got=%h want=%h", c, observe(), snap); end
        end
        ready_in = 1'b1;
        #1;
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b want=1", ready_out); end
        tick();
        valid_in = 1'b0;
        checks++; if (valid_out !== 1'b1 || result_out !== 32'd1001) begin failures++; $display("FAIL bp_release_load got=%b/%0d want=1/1001", valid_out, result_out); end
        tick();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b want=0", valid_out); end
    endtask

    task automatic test_wrap_bad();
        ready_in = 1'b1; valid_in = 1'b1;
        set_op(32'hFFFF_FFFF, 0, 1, 0, 1'b0, 2'b00, 1'b0);
        tick();
        set_op(5, 9, 32'h7, 0, 1'b0, 2'b10, 1'b0);
        checks++; if (result_out !== 32'd0 || bad_op !== 1'b0) begin failures++; $display("FAIL wrap_add got=%h/%b want=0/0", result_out, bad_op); end
        tick();
        set_op(0, 1, 32'h1, 0, 1'b0, 2'b10, 1'b0);
        checks++; if (result_out !== 32'd0 || bad_op !== 1'b1) begin failures++; $display("FAIL bad_funct got=%h/%b want=0/1", result_out, bad_op); end
        tick();
        set_op(3, 3, 32'h0, 0, 1'b0, 2'b11, 1'b0);
        checks++; if (result_out !== 32'hFFFF_FFFF || bad_op !== 1'b0) begin failures++; $display("FAIL wrap_sub got=%h/%b want=ffffffff/0", result_out, bad_op); end
        tick();
        valid_in = 1'b0;
        checks++; if (result_out !== 32'd0 || bad_op !== 1'b1) begin failures++; $display("FAIL bad_rsvd got=%h/%b want=0/1", result_out, bad_op); end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        set_op(11, 13, 32'h2, 0, 1'b0, 2'b10, 1'b0);
        valid_in = 1'b1; ready_in = 1'b1;
        tick();
        valid_in = 1'b0;
        reset = 1'b0;
        tick();
        checks++; if (valid_out !== 1'b0 || result_out !== '0) begin failures++; $display("FAIL rstmid_out got=%b/%h want=0/0", valid_out, result_out); end
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b want=1", ready_out); end
        reset = 1'b1;
        for (int c = 0; c < LAT + 2; c++) begin
            tick();
            checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rstmid_abandon c=%0d got=%b want=0", c, valid_out); end
        end
    endtask

    task automatic rand_op();
        int kind;
        logic [DW-1:0] a, b, se;
        kind = $urandom_range(0, 6);
        a  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom);
        b  = ($urandom_range(0, 3) == 0) ? a : DW'($urandom);
        se = DW'($urandom);
        case (kind)
            0: set_op(a, b, se, DW'($urandom), 1'b0, 2'b00, 1'($urandom));
            1: set_op(a, b, se, DW'($urandom), 1'($urandom), 2'b01, 1'b1);
            2, 3, 4: begin
                se[5:0] = 6'(kind - 2);
                set_op(a, b, se, DW'($urandom), ($urandom_range(0, 4) == 0), 2'b10, 1'($urandom));
            end
            5: begin
                se[5:0] = 6'($urandom_range(3, 63));
                set_op(a, b, se, DW'($urandom), 1'($urandom), 2'b10, 1'($urandom));
            end
            default: set_op(a, b, se, DW'($urandom), 1'($urandom), 2'b11, 1'($urandom));
        endcase
    endtask

    task automatic test_random();
        exp_t head;
        exp_t snap;
        logic prev_stall;
        int   mul_block;
        int   drain;
        prev_stall = 1'b0;
        mul_block  = 0;
        snap       = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            ready_in = ($urandom_range(0, 3) != 0);
            rand_op();
            #1;
            if (prev_stall) begin
                checks++; if (valid_out !== 1'b1 || observe() !== snap) begin failures++; $display("FAIL rnd_stall_hold cyc=%0d got=%h want=%h", cyc, observe(), snap); end
            end
            if (valid_out && !ready_in) begin
                checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL rnd_ready_full cyc=%0d got=%b want=0", cyc, ready_out); end
            end
            if (mul_block > 0) begin
                checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL rnd_ready_mul cyc=%0d got=%b want=0", cyc, ready_out); end
                mul_block--;
            end
            if (valid_out && ready_in) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rnd_unexpected_out cyc=%0d got=%h want=none", cyc, observe());
                end else begin
                    head = exp_q.pop_front();
                    if (observe() !== head) begin failures++; $display("FAIL rnd_out cyc=%0d got=%h want=%h", cyc, observe(), head); end
                end
            end
            if (valid_in && ready_out) begin
                exp_q.push_back(model(rs, rt, sign_ext, pc, alu_src, alu_op, branch));
                if (alu_op == 2'b10 && sign_ext[5:0] == 6'd2) mul_block = LAT - 1;
            end
            prev_stall = valid_out && !ready_in;
            snap       = observe();
            tick();
        end
        valid_in = 1'b0; ready_in = 1'b1;
        drain = 0;
        while ((exp_q.size() != 0 || valid_out) && drain < 40) begin
            #1;
            if (valid_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL drain_unexpected got=%h want=none", observe());
                end else begin
                    head = exp_q.pop_front();
                    if (observe() !== head) begin failures++; $display("FAIL drain_out got=%h want=%h", observe(), head); end
                end
            end
            tick();
            drain++;
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_missing got=%0d outstanding want=0", exp_q.size()); end
    endtask

    initial begin
        reset = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        set_op(0, 0, 0, 0, 1'b0, 2'b00, 1'b0);
`ifdef EX_FORWARD_EN
        fwd_rs_en = 1'b0; fwd_rt_en = 1'b0; fwd_data = '0;
`endif
        #1;
        test_reset();
        test_addi();
        test_beq();
        test_mul();
        test_backpressure();
        test_wrap_bad();
        test_reset_mid_mul();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_stage_pipelined.md
Name: ex_stage_pipelined

Overview:
Parametrised execute stage for the in-order MIPS-style pipeline; sits between the decode register and the memory stage.
- Computes ALU result, zero flag and branch target per operation.
- Replaces free-running stall-flag copying with a registered valid/ready handshake in both directions.
- Adds a multi-cycle multiplier that back-pressures decode while busy. All outputs are registered.

Parameters:
DATA_W, 32, datapath width of operands, result, pc and target.
MUL_LATENCY, 3, cycles a MUL occupies the stage before its result is presented (legal range 1..8).
BR_SHIFT, 2, left shift applied to sign_ext for branch offset.

Ports:
clk  in  1  pipeline clock, all state on rising edge
reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
valid_in  in  1  decode presents an operation
ready_out  out  1  stage accepts an operation this cycle
rs  in  DATA_W  operand 1
rt  in  DATA_W  operand 2 (register)
sign_ext  in  DATA_W  sign-extended immediate; bits [5:0] are funct for R-type
pc  in  DATA_W  pc of the operation
alu_src  in  1  0: data2 = rt, 1: data2 = sign_ext
alu_op  in  2  00 LW/SW/ADDI, 01 BEQ, 10 R-type, 11 reserved
branch  in  1  operation is a branch
valid_out  out  1  result registers hold a valid operation
ready_in  in  1  memory stage consumes the output this cycle
result_out  out  DATA_W  ALU result
zero_out  out  1  data1 == data2
branch_taken  out  1  branch & zero
branch_target  out  DATA_W  pc + (sign_ext << BR_SHIFT)
pc_out  out  DATA_W  branch_taken ? branch_target : pc
bad_op  out  1  reserved alu_op or unknown funct

Behaviour:
- Reset (reset == 0 at a clk edge): state = IDLE; valid_out, zero_out, branch_taken, bad_op = 0; result_out, branch_target, pc_out = 0; multiplier counter = 0. Reset mid-MUL abandons the operation, with no output.
- Operand select: data1 = rs. data2 = sign_ext when alu_op == 00, otherwise alu_src ? sign_ext : rt.
- Decode of operation:
  - alu_op 00 -> ADD.
  - alu_op 01 -> SUB.
  - alu_op 10, by funct: 000000 ADD, 000001 SUB, 000010 MUL.
  - Any other funct, or alu_op 11: result 0, bad_op = 1, latency 1.
- Arithmetic: modulo 2^DATA_W. MUL returns the low DATA_W bits of the unsigned product. Target addition wraps.
- Accept: a transfer occurs when valid_in && ready_out.
  - ready_out = (state == IDLE) && (!valid_out || ready_in), combinational from registered state.
  - Operands are captured on accept; later input changes are ignored.
- FSM:
  - IDLE: accept of a non-MUL op -> outputs loaded at the same edge (latency 1), stay IDLE.
  - IDLE: accept of MUL -> MUL_BUSY, count = MUL_LATENCY-1; if MUL_LATENCY == 1, behaves like non-MUL.
  - MUL_BUSY: count decrements each cycle. At count == 0 and output slot free (!valid_out || ready_in), load outputs and go to IDLE; otherwise hold count at 0.
- Output drain: valid_out clears at the edge where ready_in == 1, unless a new result loads at the same edge, in which case it stays 1 (back-to-back throughput of 1 op/cycle).
- Outputs hold steady while valid_out && !ready_in.
- branch_taken = branch && zero_out-equivalent, computed from captured operands. branch_target is computed for every op. pc_out = pc when not taken.

Optional Feature:
EX_FORWARD_EN:
- Defined: adds inputs fwd_rs_en, fwd_rt_en (1 bit each) and fwd_data (DATA_W). At accept, rs/rt are replaced by fwd_data when the respective enable is set; rt forwarding applies before alu_src selection.
- Undefined: ports absent, operands taken directly.

Decomposition:
- Package ex_pkg: alu_op encodings, funct codes (FN_ADD/FN_SUB/FN_MUL), FSM state enum (IDLE, MUL_BUSY), ALU control enum.
- One sub-module ex_mul_iter (DATA_W, MUL_LATENCY): start/done multi-cycle multiplier.
- Decode, ALU, branch logic and handshake stay in the top.

Test Plan:
- Reset asserted mid-stream -> next cycle valid_out = 0, result_out = 0, ready_out = 1.
- ADDI: rs = 5, sign_ext = 7, alu_op = 00, ready_in = 1 -> one cycle later result_out = 12, valid_out = 1, bad_op = 0.
- BEQ taken: rs = rt = 9, branch = 1, alu_op = 01, pc = 0x100, sign_ext = 4 -> zero_out = 1, branch_taken = 1, branch_target = 0x110, pc_out = 0x110. With rt = 8 -> pc_out = 0x100.
- MUL, MUL_LATENCY = 3: rs = 6, rt = 7, funct = 000010 -> ready_out = 0 for 2 cycles, then result_out = 42. A following ADD accepted only after.
- Back-pressure: hold ready_in = 0 with valid_out = 1 -> ready_out = 0, outputs stable for 5 cycles. Release -> next op loads at the same edge, valid_out stays 1.
- Wrap and bad op: rs = 0xFFFFFFFF + 1 -> result 0. funct = 000111 -> bad_op = 1, result 0.
